eth_rx_dispatch: RTL and testbench

- Receive-side counterpart of the ARP/UDP transmit arbiter.
- Parses each incoming GMII byte stream (preamble, SFD, destination MAC, EtherType) and forwards the complete frame, delayed, to either the ARP receiver or the UDP receiver.
- Also tracks ARP reply completion.
- Checks that received UDP payload words follow the transmit-side incrementing test pattern (seed 16'h5566).

---
 rtl/eth_pkg.sv | 32 +++
 rtl/rx_delay_line.sv | 26 ++
 rtl/eth_rx_dispatch.sv | 237 +++++++++++++++++++++++
 tb/tb_eth_rx_dispatch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, route and parser state types.
// Also holds a saturating 16-bit increment used by the statistics counters.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_HDR_LEN  = 22;

  typedef enum logic [1:0] {
    RT_DROP,
    RT_ARP,
    RT_UDP
  } route_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_BODY,
    ST_DROP
  } parser_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_delay_line.sv
// Fixed-depth shift register; every entry moves one stage per clock.
// i_clr empties the whole line on the next edge.
module rx_delay_line #(
  parameter int DEPTH = 22,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_line [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign o_q = r_line[DEPTH-1];

endmodule

// File: rtl/eth_rx_dispatch.sv
// GMII receive dispatcher: parses the header, then forwards the delayed frame to
// the ARP or UDP receiver; also tracks ARP replies and checks the UDP test pattern.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
  parameter int          HDR_LEN   = ETH_HDR_LEN,
  parameter logic [15:0] CHK_SEED  = 16'h5566
) (
  input  logic          mac_rxc,
  input  logic          rstn,
  input  logic [7:0]    mac_rxd,
  input  logic          mac_rxdv,
  output logic [7:0]    arp_mac_rxd,
  output logic          arp_mac_rxdv,
  output logic [7:0]    udp_mac_rxd,
  output logic          udp_mac_rxdv,
  input  logic          arp_rx_op,
  input  logic          arp_rx_done,
  input  logic [15:0]   udp_rx_data,
  input  logic          udp_rx_data_en,
  output logic          arp_reply_seen,
  output logic [15:0]   chk_word_cnt,
  output logic [15:0]   chk_err_cnt,
  output logic [15:0]   drop_cnt,
  output parser_state_t o_dbg_state
);

  // Streams: *_rxdv qualifies *_rxd in the same cycle; there is no backpressure,
  // so a byte is transferred on every rising edge where dv=1.

  localparam logic [4:0] IDX_SFD     = 5'd7;
  localparam logic [4:0] IDX_DST_END = 5'd13;
  localparam logic [4:0] IDX_SRC_END = 5'd19;
  localparam logic [4:0] IDX_TYPE_HI = 5'd20;
  localparam logic [4:0] IDX_BODY    = 5'(HDR_LEN);

  parser_state_t r_state, w_state_nxt;
  logic [4:0]    r_idx, w_idx_nxt, w_idx_inc;
  logic          r_dv_d;
  logic          r_dst_uc, w_dst_uc_nxt;
  logic          r_dst_bc, w_dst_bc_nxt;
  logic [7:0]    r_type_hi, w_type_hi_nxt;
  logic [15:0]   w_type;
  route_t        r_route, w_route_nxt, w_route_now;
  logic          w_drop_inc;
  logic [7:0]    w_mac_byte;

  route_t        r_out_route, w_sel;
  logic          r_dl_dv_d;
  logic [8:0]    w_dl_q;
  logic          w_dl_dv, w_dl_rise;

  logic [15:0]   r_drop_cnt, r_word_cnt, r_err_cnt, r_exp;
  logic          r_reply_seen;

  always_comb begin
    w_mac_byte = 8'h00;
    case (r_idx)
      5'd8:    w_mac_byte = LOCAL_MAC[47:40];
      5'd9:    w_mac_byte = LOCAL_MAC[39:32];
      5'd10:   w_mac_byte = LOCAL_MAC[31:24];
      5'd11:   w_mac_byte = LOCAL_MAC[23:16];
      5'd12:   w_mac_byte = LOCAL_MAC[15:8];
      5'd13:   w_mac_byte = LOCAL_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  assign w_idx_inc = r_idx + 5'd1;
  assign w_type    = {r_type_hi, mac_rxd};

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_dst_uc_nxt  = r_dst_uc;
    w_dst_bc_nxt  = r_dst_bc;
    w_type_hi_nxt = r_type_hi;
    w_route_nxt   = r_route;
    w_drop_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mac_rxdv && !r_dv_d) begin
          w_idx_nxt    = 5'd1;
          w_dst_uc_nxt = 1'b1;
          w_dst_bc_nxt = 1'b1;
          if (mac_rxd == ETH_PREAMBLE) begin
            w_state_nxt = ST_PRE;
          end else begin
            w_state_nxt = ST_DROP;
            w_route_nxt = RT_DROP;
            w_drop_inc  = 1'b1;
          end
        end
      end
      ST_PRE: begin
        w_idx_nxt = w_idx_inc;
        if (!mac_rxdv) begin
          w_state_nxt = ST_IDLE;
          w_route_nxt = RT_DROP;
          w_drop_inc  = 1'b1;
        end else if ((r_idx == IDX_SFD) ? (mac_rxd != ETH_SFD) : (mac_rxd != ETH_PREAMBLE)) begin
          w_state_nxt = ST_DROP;
          w_route_nxt = RT_DROP;
          w_drop_inc  = 1'b1;
        end else if (r_idx == IDX_SFD) begin
          w_state_nxt = ST_DST;
        end
      end
      ST_DST: begin
        w_idx_nxt    = w_idx_inc;
        w_dst_uc_nxt = r_dst_uc & (mac_rxd == w_mac_byte);
        w_dst_bc_nxt = r_dst_bc & (mac_rxd == ETH_BCAST[7:0]);
        if (!mac_rxdv) begin
          w_state_nxt = ST_IDLE;
          w_route_nxt = RT_DROP;
          w_drop_inc  = 1'b1;
        end else if (r_idx == IDX_DST_END) begin
          w_state_nxt = ST_SRC;
        end
      end
      ST_SRC: begin
        w_idx_nxt = w_idx_inc;
        if (!mac_rxdv) begin
          w_state_nxt = ST_IDLE;
          w_route_nxt = RT_DROP;
          w_drop_inc  = 1'b1;
        end else if (r_idx == IDX_SRC_END) begin
          w_state_nxt = ST_TYPE;
        end
      end
      ST_TYPE: begin
        w_idx_nxt = w_idx_inc;
        if (!mac_rxdv) begin
          w_state_nxt = ST_IDLE;
          w_route_nxt = RT_DROP;
          w_drop_inc  = 1'b1;
        end else if (r_idx == IDX_TYPE_HI) begin
          w_type_hi_nxt = mac_rxd;
        end else begin
          w_state_nxt = ST_BODY;
          if ((r_dst_uc || r_dst_bc) && w_type == ETH_TYPE_ARP) begin
            w_route_nxt = RT_ARP;
          end else if ((r_dst_uc || r_dst_bc) && w_type == ETH_TYPE_IP) begin
            w_route_nxt = RT_UDP;
          end else begin
            w_route_nxt = RT_DROP;
            w_drop_inc  = 1'b1;
          end
        end
      end
      ST_BODY: begin
        // A frame ending right after its header has nothing to deliver.
        if (r_idx == IDX_BODY) begin
          w_idx_nxt = w_idx_inc;
          if (!mac_rxdv && r_route != RT_DROP) begin
            w_route_nxt = RT_DROP;
            w_drop_inc  = 1'b1;
          end
        end
        if (!mac_rxdv) w_state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (!mac_rxdv) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  rx_delay_line #(
    .DEPTH (HDR_LEN),
    .WIDTH (9)
  ) u_delay (
    .i_clk (mac_rxc),
    .i_clr (!rstn),
    .i_d   ({mac_rxdv, mac_rxd}),
    .o_q   (w_dl_q)
  );

  // Byte 0 exits the line in the same cycle the 22-byte-frame veto is known.
  assign w_route_now = (r_state == ST_BODY && r_idx == IDX_BODY && !mac_rxdv) ? RT_DROP : r_route;
  assign w_dl_dv     = w_dl_q[8];
  assign w_dl_rise   = w_dl_dv && !r_dl_dv_d;
  assign w_sel       = w_dl_rise ? w_route_now : r_out_route;

  assign arp_mac_rxdv = w_dl_dv && (w_sel == RT_ARP);
  assign udp_mac_rxdv = w_dl_dv && (w_sel == RT_UDP);
  assign arp_mac_rxd  = arp_mac_rxdv ? w_dl_q[7:0] : 8'h00;
  assign udp_mac_rxd  = udp_mac_rxdv ? w_dl_q[7:0] : 8'h00;

  always_ff @(posedge mac_rxc) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_idx        <= 5'd0;
      r_dv_d       <= 1'b1;  // a frame already running at release is not a rising edge
      r_dst_uc     <= 1'b0;
      r_dst_bc     <= 1'b0;
      r_type_hi    <= 8'h00;
      r_route      <= RT_DROP;
      r_out_route  <= RT_DROP;
      r_dl_dv_d    <= 1'b0;
      r_drop_cnt   <= 16'h0000;
      r_word_cnt   <= 16'h0000;
      r_err_cnt    <= 16'h0000;
      r_exp        <= CHK_SEED;
      r_reply_seen <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_dv_d    <= mac_rxdv;
      r_dst_uc  <= w_dst_uc_nxt;
      r_dst_bc  <= w_dst_bc_nxt;
      r_type_hi <= w_type_hi_nxt;
      r_route   <= w_route_nxt;
      r_dl_dv_d <= w_dl_dv;
      if (w_dl_rise) r_out_route <= w_route_now;
      if (w_drop_inc) r_drop_cnt <= sat_inc16(r_drop_cnt);
      if (arp_rx_done && !arp_rx_op) r_reply_seen <= 1'b1;
      if (udp_rx_data_en) begin
        r_word_cnt <= sat_inc16(r_word_cnt);
        if (udp_rx_data == r_exp) begin
          r_exp <= r_exp + 16'd1;
        end else begin
          r_err_cnt <= sat_inc16(r_err_cnt);
          r_exp     <= udp_rx_data + 16'd1;
        end
      end
    end
  end

  assign drop_cnt       = r_drop_cnt;
  assign chk_word_cnt   = r_word_cnt;
  assign chk_err_cnt    = r_err_cnt;
  assign arp_reply_seen = r_reply_seen;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Self-checking bench for eth_rx_dispatch: frame drivers push expected bytes with
// their exit cycle into per-port queues; a negedge monitor pops and compares them.
module tb_eth_rx_dispatch;
  import eth_pkg::*;

  localparam logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;
  localparam int          LAT       = 22;

  logic          mac_rxc = 1'b0;
  logic          rstn    = 1'b0;
  logic [7:0]    mac_rxd = 8'h00;
  logic          mac_rxdv = 1'b0;
  logic [7:0]    arp_mac_rxd, udp_mac_rxd;
  logic          arp_mac_rxdv, udp_mac_rxdv;
  logic          arp_rx_op = 1'b0;
  logic          arp_rx_done = 1'b0;
  logic [15:0]   udp_rx_data = 16'h0000;
  logic          udp_rx_data_en = 1'b0;
  logic          arp_reply_seen;
  logic [15:0]   chk_word_cnt, chk_err_cnt, drop_cnt;
  parser_state_t dbg_state;

  eth_rx_dispatch dut (
    .mac_rxc        (mac_rxc),
    .rstn           (rstn),
    .mac_rxd        (mac_rxd),
    .mac_rxdv       (mac_rxdv),
    .arp_mac_rxd    (arp_mac_rxd),
    .arp_mac_rxdv   (arp_mac_rxdv),
    .udp_mac_rxd    (udp_mac_rxd),
    .udp_mac_rxdv   (udp_mac_rxdv),
    .arp_rx_op      (arp_rx_op),
    .arp_rx_done    (arp_rx_done),
    .udp_rx_data    (udp_rx_data),
    .udp_rx_data_en (udp_rx_data_en),
    .arp_reply_seen (arp_reply_seen),
    .chk_word_cnt   (chk_word_cnt),
    .chk_err_cnt    (chk_err_cnt),
    .drop_cnt       (drop_cnt),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  always #4 mac_rxc = ~mac_rxc;

  int cyc = 0;
  always @(posedge mac_rxc) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {exit cycle, byte}
  logic [39:0] arp_exp_q[$];
  logic [39:0] udp_exp_q[$];
  int          exp_drop = 0;
  logic [7:0]  fb [0:127];

  always @(negedge mac_rxc) begin
    logic [39:0] e;
    if (arp_mac_rxdv) begin
      if (arp_exp_q.size() == 0) check("arp_unexpected_dv", 48'd1, 48'd0);
      else begin
        e = arp_exp_q.pop_front();
        check("arp_data", 48'(arp_mac_rxd), 48'(e[7:0]));
        check("arp_cycle", 48'(cyc), 48'(e[39:8]));
      end
    end else check("arp_idle_data", 48'(arp_mac_rxd), 48'd0);
    if (udp_mac_rxdv) begin
      if (udp_exp_q.size() == 0) check("udp_unexpected_dv", 48'd1, 48'd0);
      else begin
        e = udp_exp_q.pop_front();
        check("udp_data", 48'(udp_mac_rxd), 48'(e[7:0]));
        check("udp_cycle", 48'(cyc), 48'(e[39:8]));
      end
    end else check("udp_idle_data", 48'(udp_mac_rxd), 48'd0);
  end

  // driver tasks
  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input int len,
                       input logic [7:0] sfd);
    logic [47:0] src;
    src = {8'h02, 8'(($urandom_range(0, 255))), 32'hBBCC_DDEE};
    for (int i = 0; i < len; i++) begin
      if (i < 7)       fb[i] = ETH_PREAMBLE;
      else if (i == 7) fb[i] = sfd;
      else if (i < 14) fb[i] = dst[8*(13-i) +: 8];
      else if (i < 20) fb[i] = src[8*(19-i) +: 8];
      else if (i == 20) fb[i] = etype[15:8];
      else if (i == 21) fb[i] = etype[7:0];
      else             fb[i] = 8'($urandom_range(0, 255));
    end
  endtask

  function automatic route_t model_route(input int len);
    logic        pre_ok;
    logic [47:0] dst;
    logic [15:0] et;
    if (len <= LAT) return RT_DROP;
    pre_ok = (fb[7] == 8'hD5);
    for (int i = 0; i < 7; i++) if (fb[i] != 8'h55) pre_ok = 1'b0;
    dst = {fb[8], fb[9], fb[10], fb[11], fb[12], fb[13]};
    et  = {fb[20], fb[21]};
    if (!pre_ok) return RT_DROP;
    if (dst != LOCAL_MAC && dst != 48'hFFFF_FFFF_FFFF) return RT_DROP;
    if (et == 16'h0806) return RT_ARP;
    if (et == 16'h0800) return RT_UDP;
    return RT_DROP;
  endfunction

  task automatic send(input int len);
    route_t r;
    r = model_route(len);
    if (r == RT_DROP) exp_drop++;
    for (int i = 0; i < len; i++) begin
      @(posedge mac_rxc); #1;
      mac_rxd  = fb[i];
      mac_rxdv = 1'b1;
      if (r == RT_ARP) arp_exp_q.push_back({32'(cyc + LAT), fb[i]});
      if (r == RT_UDP) udp_exp_q.push_back({32'(cyc + LAT), fb[i]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mac_rxc); #1;
      mac_rxd  = 8'h00;
      mac_rxdv = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (arp_exp_q.size() != 0 || udp_exp_q.size() != 0); i++)
      @(posedge mac_rxc);
    #1;
    check({tag, "_arp_left"}, 48'(arp_exp_q.size()), 48'd0);
    check({tag, "_udp_left"}, 48'(udp_exp_q.size()), 48'd0);
    check({tag, "_drop_cnt"}, 48'(drop_cnt), 48'(exp_drop));
  endtask

  task automatic word(input logic [15:0] w);
    @(posedge mac_rxc); #1;
    udp_rx_data    = w;
    udp_rx_data_en = 1'b1;
  endtask

  initial begin
    int ln;
    repeat (3) @(posedge mac_rxc);
    #1;
    check("rst_arp_dv", 48'(arp_mac_rxdv), 48'd0);
    check("rst_udp_dv", 48'(udp_mac_rxdv), 48'd0);
    check("rst_drop", 48'(drop_cnt), 48'd0);
    check("rst_words", 48'(chk_word_cnt), 48'd0);
    check("rst_errs", 48'(chk_err_cnt), 48'd0);
    check("rst_reply", 48'(arp_reply_seen), 48'd0);
    check("rst_state", 48'(dbg_state), 48'(ST_IDLE));
    rstn = 1'b1;

    // broadcast ARP, then IP to this board
    build(ETH_BCAST, ETH_TYPE_ARP, 64, ETH_SFD); send(64); idle(20); drain("bcast_arp");
    build(LOCAL_MAC, ETH_TYPE_IP, 80, ETH_SFD);  send(80); idle(20); drain("local_ip");

    // foreign destination then ARP after minimum gap; forwarded UDP then ARP after minimum gap
    build(OTHER_MAC, ETH_TYPE_IP, 70, ETH_SFD);  send(70); idle(12);
    build(LOCAL_MAC, ETH_TYPE_ARP, 60, ETH_SFD); send(60); idle(20); drain("foreign_then_arp");
    build(LOCAL_MAC, ETH_TYPE_IP, 50, ETH_SFD);  send(50); idle(12);
    build(ETH_BCAST, ETH_TYPE_ARP, 40, ETH_SFD); send(40); idle(20); drain("udp_then_arp");

    // bad SFD, runt, header-only frame, and the shortest forwarded frame
    build(LOCAL_MAC, ETH_TYPE_ARP, 64, 8'hD4); send(64); idle(12);
    build(LOCAL_MAC, ETH_TYPE_ARP, 10, ETH_SFD); send(10); idle(20); drain("sfd_runt");
    build(LOCAL_MAC, ETH_TYPE_ARP, 22, ETH_SFD); send(22); idle(20); drain("len22");
    build(LOCAL_MAC, ETH_TYPE_IP, 23, ETH_SFD);  send(23); idle(20); drain("len23");

    // random mix
    for (int k = 0; k < 6; k++) begin
      logic [47:0] d;
      logic [15:0] t;
      case ($urandom_range(0, 2))
        0:       d = LOCAL_MAC;
        1:       d = ETH_BCAST;
        default: d = OTHER_MAC;
      endcase
      case ($urandom_range(0, 2))
        0:       t = ETH_TYPE_ARP;
        1:       t = ETH_TYPE_IP;
        default: t = 16'h86DD;
      endcase
      ln = $urandom_range(23, 90);
      build(d, t, ln, ETH_SFD); send(ln); idle($urandom_range(12, 20));
    end
    idle(10); drain("random");

    // payload checker
    word(16'h5566); word(16'h5567); word(16'h5568); word(16'h1234); word(16'h1235);
    @(posedge mac_rxc); #1; udp_rx_data_en = 1'b0;
    check("chk_words_5", 48'(chk_word_cnt), 48'd5);
    check("chk_errs_1", 48'(chk_err_cnt), 48'd1);
    word(16'h1236);
    @(posedge mac_rxc); #1; udp_rx_data_en = 1'b0;
    check("chk_resync_words", 48'(chk_word_cnt), 48'd6);
    check("chk_resync_errs", 48'(chk_err_cnt), 48'd1);
    word(16'hFFFF); word(16'h0000);
    @(posedge mac_rxc); #1; udp_rx_data_en = 1'b0;
    check("chk_wrap_words", 48'(chk_word_cnt), 48'd8);
    check("chk_wrap_errs", 48'(chk_err_cnt), 48'd2);

    // reset while a frame is leaving the delay line
    build(LOCAL_MAC, ETH_TYPE_ARP, 64, ETH_SFD);
    for (int i = 0; i < 64; i++) begin
      @(posedge mac_rxc); #1;
      if (i == 41) begin
        rstn = 1'b1;
        check("midrst_arp_dv", 48'(arp_mac_rxdv), 48'd0);
        check("midrst_drop", 48'(drop_cnt), 48'd0);
        check("midrst_words", 48'(chk_word_cnt), 48'd0);
      end
      mac_rxd  = fb[i];
      mac_rxdv = 1'b1;
      if (i < 40) arp_exp_q.push_back({32'(cyc + LAT), fb[i]});
      if (i == 40) begin
        rstn     = 1'b0;
        exp_drop = 0;
        while (arp_exp_q.size() != 0 && int'(arp_exp_q[$][39:8]) > cyc) void'(arp_exp_q.pop_back());
      end
    end
    idle(40); drain("midrst");

    // ARP reply tracking
    @(posedge mac_rxc); #1; arp_rx_op = 1'b1; arp_rx_done = 1'b1;
    @(posedge mac_rxc); #1; arp_rx_done = 1'b0;
    @(posedge mac_rxc); #1;
    check("reply_after_req", 48'(arp_reply_seen), 48'd0);
    arp_rx_op = 1'b0; arp_rx_done = 1'b1;
    @(posedge mac_rxc); #1; arp_rx_done = 1'b0;
    @(posedge mac_rxc); #1;
    check("reply_after_rep", 48'(arp_reply_seen), 48'd1);

    // final report
    repeat (4) @(posedge mac_rxc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
